// File: rtl/serial_pkg.sv
// Shared line-level constants and state encoding for the serial link.
// The future matching receiver uses the same definitions.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Counter/index width that stays at least one bit wide for n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Load handshake and serial-line bundle between a word producer and serial_tx.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             tx_out;
  logic             busy;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, tx_out, busy, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, tx_out, busy, done
  );
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear || restart || cnt == LAST) cnt <= '0;
    else                                 cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks. All outputs are registered.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        clear,
  serial_tx_if.slave bus
);

  localparam int               IDX_W    = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tx, tx_nxt;
  logic             busy, busy_nxt;
  logic             ready, ready_nxt;
  logic             done, done_nxt;
  logic             tick;

  // Timer is held at zero while idle so the start bit gets a full period.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .clear   (clear),
    .restart (state == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      tx    <= IDLE_LVL;
      busy  <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      idx   <= idx_nxt;
      tx    <= tx_nxt;
      busy  <= busy_nxt;
      ready <= ready_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    idx_nxt   = idx;
    tx_nxt    = tx;
    busy_nxt  = busy;
    ready_nxt = ready;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load_valid && ready) begin
          shift_nxt = bus.din;
          idx_nxt   = '0;
          state_nxt = START;
          tx_nxt    = START_LVL;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            state_nxt = STOP;
            tx_nxt    = STOP_LVL;
          end else begin
            // Next line level comes from the already-shifted register.
            shift_nxt = shift >> 1;
            idx_nxt   = idx + IDX_W'(1);
            tx_nxt    = shift_nxt[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          tx_nxt    = IDLE_LVL;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign bus.tx_out     = tx;
  assign bus.busy       = busy;
  assign bus.load_ready = ready;
  assign bus.done       = done;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table of frames fed through a per-cycle
// expected-output scoreboard, plus hand-written reset, abort and C=1 sequences.
module tb_serial_tx;

  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic clear;
  logic clear1;

  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W)) bus ();
  serial_tx_if #(.WIDTH(1)) bus1 ();

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clk   (clk),
    .clear (clear1),
    .bus   (bus1)
  );

  typedef struct {
    logic tx;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  typedef struct {
    logic [W-1:0] din;
    logic [9:0]   wave;   // wave[9] is the start bit, wave[0] the stop bit
    bit           hostile;
  } vec_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_main(input exp_t e, input string tag);
    check({tag, " tx_out"},     bus.tx_out,     e.tx);
    check({tag, " busy"},       bus.busy,       e.busy);
    check({tag, " load_ready"}, bus.load_ready, e.ready);
    check({tag, " done"},       bus.done,       e.done);
  endtask

  task automatic push_wave(input logic [9:0] wave);
    for (int i = 9; i >= 0; i--)
      for (int k = 0; k < C; k++) sbq.push_back('{wave[i], 1'b1, 1'b0, 1'b0});
    sbq.push_back('{1'b1, 1'b0, 1'b1, 1'b1});
  endtask

  // Accept one word and check every cycle through the done cycle. Returns
  // positioned in the done cycle with load_valid low.
  task automatic send(input logic [W-1:0] d, input logic [9:0] wave, input bit hostile,
                      input string tag);
    exp_t e;
    int   cyc;
    bus.din        = d;
    bus.load_valid = 1'b1;
    push_wave(wave);
    tick();
    bus.load_valid = 1'b0;
    cyc = 1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp_main(e, $sformatf("%s c%0d", tag, cyc));
      if (sbq.size() > 0) begin
        if (hostile) begin
          bus.load_valid = 1'b1;
          bus.din        = W'($urandom);
        end
        tick();
        cyc++;
      end
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    exp_t e;
    bus.load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
      tick();
      e = sbq.pop_front();
      cmp_main(e, $sformatf("%s idle%0d", tag, i));
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'hA5, 10'b0101001011, 1'b1};
    vecs[2] = '{8'h01, 10'b0100000001, 1'b0};
    vecs[3] = '{8'h80, 10'b0000000011, 1'b1};
    vecs[4] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[5] = '{8'hFF, 10'b0111111111, 1'b0};

    // Reset with load_valid asserted: no accept may happen.
    clear           = 1'b1;
    clear1          = 1'b1;
    bus.din         = 8'h55;
    bus.load_valid  = 1'b1;
    bus1.din        = 1'b1;
    bus1.load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_main('{1'b1, 1'b0, 1'b1, 1'b0}, $sformatf("reset%0d", i));
    end
    clear          = 1'b0;
    clear1         = 1'b0;
    bus.load_valid = 1'b0;
    bus1.load_valid = 1'b0;
    idle_cycles(2, "post_reset");

    // Table-driven frames, some with load_valid/din noise during the frame.
    foreach (vecs[i]) begin
      send(vecs[i].din, vecs[i].wave, vecs[i].hostile, $sformatf("vec%0d", i));
      idle_cycles(3, $sformatf("vec%0d", i));
    end

    // Back-to-back: second accept lands in the done cycle of the first.
    send(8'h00, 10'b0000000001, 1'b1, "b2b0");
    send(8'hFF, 10'b0111111111, 1'b0, "b2b1");
    idle_cycles(2, "b2b");

    // Abort mid-frame with clear sampled at the edge ending cycle 20.
    begin
      exp_t e;
      bus.din        = 8'hA5;
      bus.load_valid = 1'b1;
      push_wave(10'b0101001011);
      tick();
      bus.load_valid = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        e = sbq.pop_front();
        cmp_main(e, $sformatf("abort c%0d", cyc));
        if (cyc < 20) tick();
      end
      sbq.delete();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      cmp_main('{1'b1, 1'b0, 1'b1, 1'b0}, "abort c21");
      idle_cycles(C * 6, "abort");
      send(8'h3C, 10'b0001111001, 1'b0, "after_abort");
      idle_cycles(1, "after_abort");
    end

    // WIDTH=1, CLKS_PER_BIT=1: start, data, stop, then done in cycle 4.
    for (int v = 0; v < 2; v++) begin
      logic d;
      d = (v == 0) ? 1'b1 : 1'b0;
      bus1.din        = d;
      bus1.load_valid = 1'b1;
      tick();
      bus1.load_valid = 1'b0;
      for (int cyc = 1; cyc <= 5; cyc++) begin
        logic etx, ebusy, eready, edone;
        etx    = (cyc == 1) ? 1'b0 : (cyc == 2) ? d : 1'b1;
        ebusy  = (cyc <= 3);
        eready = (cyc >= 4);
        edone  = (cyc == 4);
        check($sformatf("w1 d%0d c%0d tx_out", d, cyc),     bus1.tx_out,     etx);
        check($sformatf("w1 d%0d c%0d busy", d, cyc),       bus1.busy,       ebusy);
        check($sformatf("w1 d%0d c%0d load_ready", d, cyc), bus1.load_ready, eready);
        check($sformatf("w1 d%0d c%0d done", d, cyc),       bus1.done,       edone);
        if (cyc < 5) tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
